// File: rtl/mips_pkg.sv
// Shared definitions for the P4 MIPS core: next-PC select codes, fetch FSM encoding
// and the architectural reset / exception vectors.
package mips_pkg;

    localparam logic [2:0] PCSRC_PC4    = 3'b000;
    localparam logic [2:0] PCSRC_BRANCH = 3'b001;
    localparam logic [2:0] PCSRC_JUMP   = 3'b010;
    localparam logic [2:0] PCSRC_REG    = 3'b011;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Signal bundle between the fetch stage and its surroundings (control, GPR file,
// instruction memory, decode). The fetch unit uses the master view.
interface fetch_pc_unit_if;

    logic [2:0]  pcsrc;
    logic [15:0] imm16;
    logic [25:0] instr26;
    logic [31:0] regtarget;
    logic        advance;
    logic        imemreq;
    logic [31:0] imemaddr;
    logic        imemready;
    logic [31:0] imemrdata;
    logic [31:0] instr;
    logic        instrvalid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        addrerr;

    modport master (
        input  pcsrc, imm16, instr26, regtarget, advance, imemready, imemrdata,
        output imemreq, imemaddr, instr, instrvalid, pc, pcplus4, addrerr
    );

    modport slave (
        output pcsrc, imm16, instr26, regtarget, advance, imemready, imemrdata,
        input  imemreq, imemaddr, instr, instrvalid, pc, pcplus4, addrerr
    );

endinterface

// File: rtl/fetch_pc_unit_npc_calc.sv
// Purely combinational next-PC selection: sequential, branch, jump and register targets.
module npc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  pcsrc,
    input  logic [15:0] imm16,
    input  logic [25:0] instr26,
    input  logic [31:0] regtarget,
    output logic [31:0] pcplus4,
    output logic [31:0] npc
);

    logic [31:0] br_off;

    assign pcplus4 = pc + 32'd4;
    assign br_off  = {{14{imm16[15]}}, imm16, 2'b00};

    // Adds wrap modulo 2^32 without any flag; undefined selects fall back to PC+4.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        npc = pcplus4;
        case (pcsrc)
            PCSRC_BRANCH: npc = pcplus4 + br_off;
            PCSRC_JUMP:   npc = {pcplus4[31:28], instr26, 2'b00};
            PCSRC_REG:    npc = regtarget;
            default:      npc = pcplus4;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and instruction-fetch FSM (FETCH/HOLD) with a ready-handshaked imem request.
// Build option PC_ALIGN_CHECK_EN: misaligned next-PC redirects to EXC_PC and sets sticky addrerr.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_PC   = EXC_PC_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    fetch_pc_unit_if.master bus
);

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    fetch_state_e state, state_next;

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        addr_err_q;
    logic [31:0] npc;
    logic [31:0] pcplus4;
    logic        misaligned;
    logic        capture;
    logic        take_npc;
    logic        instr_valid;

    npc_calc u_npc_calc (
        .pc        (pc_q),
        .pcsrc     (bus.pcsrc),
        .imm16     (bus.imm16),
        .instr26   (bus.instr26),
        .regtarget (bus.regtarget),
        .pcplus4   (pcplus4),
        .npc       (npc)
    );

    assign misaligned = (npc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FETCH;
        else          state <= state_next;
    end

    // A response only counts once the registered request is actually visible to imem.
    always_comb begin
        state_next = state;
        case (state)
            FETCH: if (req_q && bus.imemready) state_next = HOLD;
            HOLD:  if (bus.advance)            state_next = FETCH;
        endcase
    end

    always_comb begin
        capture     = 1'b0;
        take_npc    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            FETCH: capture = req_q && bus.imemready;
            HOLD: begin
                instr_valid = 1'b1;
                take_npc    = bus.advance;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            req_q      <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
            req_q <= (state_next == FETCH);
            if (capture) instr_q <= bus.imemrdata;
            if (take_npc) begin
                if (ALIGN_CHECK && misaligned) begin
                    pc_q       <= EXC_PC;
                    addr_err_q <= 1'b1;
                end else begin
                    pc_q <= npc;
                end
            end
        end
    end

    assign bus.imemreq    = req_q;
    assign bus.imemaddr   = {pc_q[31:2], 2'b00};
    assign bus.instr      = instr_q;
    assign bus.instrvalid = instr_valid;
    assign bus.pc         = pc_q;
    assign bus.pcplus4    = pcplus4;
    assign bus.addrerr    = addr_err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus randomized traffic
// against a behavioural next-PC model. Honours PC_ALIGN_CHECK_EN when defined.
module tb_fetch_pc_unit;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC    = 32'h0000_4180;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(.RESET_PC(RST_PC), .EXC_PC(EXC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_err;

    function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [2:0] src,
                                            input logic [15:0] imm, input logic [25:0] idx,
                                            input logic [31:0] rt);
        logic [31:0] link;
        int off;
        link = pc + 32'd4;
        off  = int'($signed(imm));
        case (src)
            3'd0:    return link;
            3'd1:    return link + 32'(off * 4);
            3'd2:    return (link & 32'hF000_0000) + 32'(idx) * 32'd4;
            3'd3:    return rt;
            default: return link;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.advance   = 1'b0;
        bus.imemready = 1'b0;
        bus.imemrdata = '0;
        bus.pcsrc     = '0;
        bus.imm16     = '0;
        bus.instr26   = '0;
        bus.regtarget = '0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset_n = 1'b1;
        m_pc  = RST_PC;
        m_err = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] word, input int stall, input string tag);
        int budget = 0;
        while (bus.imemreq !== 1'b1 && budget < 10) begin
            tick();
            budget++;
        end
        checks++;
        if (bus.imemreq !== 1'b1) begin
            errors++;
            $display("FAIL %s req_timeout imemreq=%b required 1", tag, bus.imemreq);
        end
        checks++;
        if (bus.imemaddr !== (m_pc & 32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL %s imemaddr got %h required %h", tag, bus.imemaddr, m_pc & 32'hFFFF_FFFC);
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            checks++;
            if (bus.imemreq !== 1'b1 || bus.imemaddr !== (m_pc & 32'hFFFF_FFFC) || bus.instrvalid !== 1'b0) begin
                errors++;
                $display("FAIL %s stall_hold req=%b addr=%h valid=%b required 1 %h 0",
                         tag, bus.imemreq, bus.imemaddr, bus.instrvalid, m_pc & 32'hFFFF_FFFC);
            end
        end
        bus.imemrdata = word;
        bus.imemready = 1'b1;
        tick();
        bus.imemready = 1'b0;
        bus.imemrdata = $urandom;
        m_instr = word;
        checks++;
        if (bus.instrvalid !== 1'b1 || bus.instr !== word) begin
            errors++;
            $display("FAIL %s capture valid=%b instr=%h required 1 %h", tag, bus.instrvalid, bus.instr, word);
        end
        checks++;
        if (bus.pc !== m_pc || bus.pcplus4 !== m_pc + 32'd4 || bus.imemreq !== 1'b0) begin
            errors++;
            $display("FAIL %s hold_pc pc=%h pc4=%h req=%b required %h %h 0",
                     tag, bus.pc, bus.pcplus4, bus.imemreq, m_pc, m_pc + 32'd4);
        end
        checks++;
        if (bus.addrerr !== m_err) begin
            errors++;
            $display("FAIL %s addrerr got %b required %b", tag, bus.addrerr, m_err);
        end
    endtask

    task automatic advance(input logic [2:0] src, input logic [15:0] imm, input logic [25:0] idx,
                           input logic [31:0] rt, input string tag);
        logic [31:0] n;
        bus.pcsrc     = src;
        bus.imm16     = imm;
        bus.instr26   = idx;
        bus.regtarget = rt;
        bus.advance   = 1'b1;
        tick();
        bus.advance   = 1'b0;
        bus.pcsrc     = 3'($urandom_range(0, 7));
        bus.imm16     = 16'($urandom);
        bus.instr26   = 26'($urandom);
        bus.regtarget = $urandom;
        n = ref_npc(m_pc, src, imm, idx, rt);
`ifdef PC_ALIGN_CHECK_EN
        if (n % 4 != 0) begin
            m_pc  = EXC;
            m_err = 1'b1;
        end else begin
            m_pc = n;
        end
`else
        m_pc = n;
`endif
        checks++;
        if (bus.instrvalid !== 1'b0 || bus.pc !== m_pc) begin
            errors++;
            $display("FAIL %s advance valid=%b pc=%h required 0 %h", tag, bus.instrvalid, bus.pc, m_pc);
        end
        checks++;
        if (bus.imemreq !== 1'b1 || bus.imemaddr !== (m_pc & 32'hFFFF_FFFC) || bus.addrerr !== m_err) begin
            errors++;
            $display("FAIL %s refetch req=%b addr=%h err=%b required 1 %h %b",
                     tag, bus.imemreq, bus.imemaddr, bus.addrerr, m_pc & 32'hFFFF_FFFC, m_err);
        end
    endtask

    task automatic hold_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.imemready = 1'($urandom);
            bus.imemrdata = $urandom;
            tick();
            checks++;
            if (bus.instrvalid !== 1'b1 || bus.instr !== m_instr || bus.pc !== m_pc || bus.imemreq !== 1'b0) begin
                errors++;
                $display("FAIL %s hold valid=%b instr=%h pc=%h req=%b required 1 %h %h 0",
                         tag, bus.instrvalid, bus.instr, bus.pc, bus.imemreq, m_instr, m_pc);
            end
        end
        bus.imemready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        bus.imemready = 1'b1;
        bus.imemrdata = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (bus.pc !== RST_PC || bus.instrvalid !== 1'b0 || bus.imemreq !== 1'b0 ||
            bus.instr !== 32'h0 || bus.addrerr !== 1'b0) begin
            errors++;
            $display("FAIL reset_values pc=%h valid=%b req=%b instr=%h err=%b required %h 0 0 0 0",
                     bus.pc, bus.instrvalid, bus.imemreq, bus.instr, bus.addrerr, RST_PC);
        end
        reset_n = 1'b1;
        m_pc  = RST_PC;
        m_err = 1'b0;
        bus.imemrdata = 32'h2408_0001;
        tick();
        checks++;
        if (bus.imemreq !== 1'b1 || bus.imemaddr !== RST_PC || bus.instrvalid !== 1'b0) begin
            errors++;
            $display("FAIL first_req req=%b addr=%h valid=%b required 1 %h 0",
                     bus.imemreq, bus.imemaddr, bus.instrvalid, RST_PC);
        end
        tick();
        bus.imemready = 1'b0;
        m_instr = 32'h2408_0001;
        checks++;
        if (bus.instrvalid !== 1'b1 || bus.instr !== 32'h2408_0001 || bus.pc !== RST_PC) begin
            errors++;
            $display("FAIL first_fetch valid=%b instr=%h pc=%h required 1 24080001 %h",
                     bus.instrvalid, bus.instr, bus.pc, RST_PC);
        end
    endtask

    task automatic test_pc4_stall();
        hold_cycles(2, "pc4_hold");
        advance(PCSRC_PC4, 16'h0, 26'h0, 32'h0, "pc4");
        checks++;
        if (bus.imemaddr !== 32'h0000_3004) begin
            errors++;
            $display("FAIL pc4_addr got %h required 00003004", bus.imemaddr);
        end
        fetch($urandom, 3, "pc4_stall");
    endtask

    task automatic test_branch();
        advance(PCSRC_REG, 16'h0, 26'h0, 32'h0000_3010, "br_setup");
        fetch($urandom, 0, "br_setup");
        advance(PCSRC_BRANCH, 16'hFFFE, 26'h0, 32'h0, "br_back");
        checks++;
        if (bus.pc !== 32'h0000_300C) begin
            errors++;
            $display("FAIL br_back_pc got %h required 0000300c", bus.pc);
        end
        fetch($urandom, 1, "br_back");
        advance(PCSRC_REG, 16'h0, 26'h0, 32'h0000_3010, "br_setup2");
        fetch($urandom, 0, "br_setup2");
        advance(PCSRC_BRANCH, 16'h0003, 26'h0, 32'h0, "br_fwd");
        checks++;
        if (bus.pc !== 32'h0000_3020) begin
            errors++;
            $display("FAIL br_fwd_pc got %h required 00003020", bus.pc);
        end
        fetch($urandom, 0, "br_fwd");
    endtask

    task automatic test_jump();
        advance(PCSRC_REG, 16'h0, 26'h0, 32'h0000_3000, "j_setup");
        fetch($urandom, 0, "j_setup");
        advance(PCSRC_JUMP, 16'h0, 26'h000_0C40, 32'h0, "jal");
        checks++;
        if (bus.pc !== 32'h0000_3100) begin
            errors++;
            $display("FAIL jal_pc got %h required 00003100", bus.pc);
        end
        fetch($urandom, 2, "jal");
        advance(PCSRC_REG, 16'h0, 26'h0, 32'h0000_3040, "jr");
        checks++;
        if (bus.pc !== 32'h0000_3040) begin
            errors++;
            $display("FAIL jr_pc got %h required 00003040", bus.pc);
        end
        fetch($urandom, 0, "jr");
    endtask

    task automatic test_wrap();
        advance(PCSRC_REG, 16'h0, 26'h0, 32'hFFFF_FFFC, "wrap_setup");
        fetch($urandom, 0, "wrap_setup");
        advance(PCSRC_PC4, 16'h0, 26'h0, 32'h0, "wrap_pc4");
        checks++;
        if (bus.pc !== 32'h0 || bus.addrerr !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pc got %h err=%b required 00000000 0", bus.pc, bus.addrerr);
        end
        fetch($urandom, 0, "wrap_pc4");
        advance(PCSRC_BRANCH, 16'hFFFF, 26'h0, 32'h0, "wrap_br");
        checks++;
        if (bus.pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_br_pc got %h required 00000000", bus.pc);
        end
        fetch($urandom, 0, "wrap_br");
        advance(PCSRC_BRANCH, 16'h7FFF, 26'h0, 32'h0, "undef_sel_setup");
        fetch($urandom, 0, "undef_sel_setup");
        advance(3'b110, 16'h1234, 26'h3FF_FFFF, 32'h0000_5555, "undef_sel");
        fetch($urandom, 0, "undef_sel");
    endtask

    task automatic test_align();
        advance(PCSRC_REG, 16'h0, 26'h0, 32'h0000_3002, "misalign");
`ifdef PC_ALIGN_CHECK_EN
        checks++;
        if (bus.pc !== EXC || bus.addrerr !== 1'b1) begin
            errors++;
            $display("FAIL misalign_exc pc=%h err=%b required %h 1", bus.pc, bus.addrerr, EXC);
        end
        fetch($urandom, 0, "misalign");
        advance(PCSRC_PC4, 16'h0, 26'h0, 32'h0, "sticky");
        checks++;
        if (bus.pc !== 32'h0000_4184 || bus.addrerr !== 1'b1) begin
            errors++;
            $display("FAIL sticky pc=%h err=%b required 00004184 1", bus.pc, bus.addrerr);
        end
        fetch($urandom, 0, "sticky");
        apply_reset();
        checks++;
        if (bus.addrerr !== 1'b0 || bus.pc !== RST_PC) begin
            errors++;
            $display("FAIL err_clear err=%b pc=%h required 0 %h", bus.addrerr, bus.pc, RST_PC);
        end
        fetch($urandom, 0, "after_err_reset");
`else
        checks++;
        if (bus.pc !== 32'h0000_3002 || bus.imemaddr !== 32'h0000_3000 || bus.addrerr !== 1'b0) begin
            errors++;
            $display("FAIL misalign_raw pc=%h addr=%h err=%b required 00003002 00003000 0",
                     bus.pc, bus.imemaddr, bus.addrerr);
        end
        fetch($urandom, 0, "misalign");
        advance(PCSRC_REG, 16'h0, 26'h0, 32'h0000_3000, "realign");
        fetch($urandom, 0, "realign");
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            advance(PCSRC_PC4, 16'h0, 26'h0, 32'h0, "b2b");
            fetch($urandom, 0, "b2b");
        end
    endtask

    task automatic test_random();
        logic [2:0]  src;
        logic [31:0] rt;
        for (int i = 0; i < 60; i++) begin
            hold_cycles($urandom_range(0, 2), "rnd_hold");
            src = 3'($urandom_range(0, 7));
            rt  = $urandom;
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            advance(src, 16'($urandom), 26'($urandom), rt, "rnd");
            fetch($urandom, $urandom_range(0, 3), "rnd");
        end
    endtask

    task automatic test_reset_mid_fetch();
        advance(PCSRC_PC4, 16'h0, 26'h0, 32'h0, "mid_setup");
        tick();
        reset_n = 1'b0;
        bus.imemready = 1'b1;
        bus.imemrdata = 32'hCAFE_F00D;
        #1;
        checks++;
        if (bus.instrvalid !== 1'b0 || bus.pc !== RST_PC || bus.imemreq !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset valid=%b pc=%h req=%b required 0 %h 0",
                     bus.instrvalid, bus.pc, bus.imemreq, RST_PC);
        end
        tick();
        bus.imemready = 1'b0;
        reset_n = 1'b1;
        m_pc  = RST_PC;
        m_err = 1'b0;
        tick();
        checks++;
        if (bus.imemreq !== 1'b1 || bus.imemaddr !== RST_PC || bus.instrvalid !== 1'b0 || bus.instr !== 32'h0) begin
            errors++;
            $display("FAIL restart req=%b addr=%h valid=%b instr=%h required 1 %h 0 0",
                     bus.imemreq, bus.imemaddr, bus.instrvalid, bus.instr, RST_PC);
        end
        fetch($urandom, 1, "restart");
    endtask

    initial begin
        test_reset();
        test_pc4_stall();
        test_branch();
        test_jump();
        test_wrap();
        test_align();
        test_back_to_back();
        test_random();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
